// File: rtl/neurosa_pkg.sv
//------------------------------------------------------------------------------
// Module : neurosa_pkg
// Brief  : Shared widths, spike encodings, packet and state types for the
//          neuro-annealing spike network.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package neurosa_pkg;

    localparam int FP_DATA_WIDTH   = 16;
    localparam int TEN_DATA_WIDTH  = 2;
    localparam int NUM_NEURON      = 64;
    localparam int NEURON_ID_WIDTH = 10;
    localparam int SPIKE_IN_WIDTH  = TEN_DATA_WIDTH + NEURON_ID_WIDTH;

    localparam logic [TEN_DATA_WIDTH-1:0] SPK_POS  = 2'b10;
    localparam logic [TEN_DATA_WIDTH-1:0] SPK_NEG  = 2'b01;
    localparam logic [TEN_DATA_WIDTH-1:0] SPK_NONE = 2'b00;

    typedef struct packed {
        logic [TEN_DATA_WIDTH-1:0]  value;
        logic [NEURON_ID_WIDTH-1:0] id;
    } spike_pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } bcast_state_t;

    // 2'b11 is an invalid code and counts as "no spike"
    function automatic logic is_spike(input logic [TEN_DATA_WIDTH-1:0] v);
        return (v == SPK_POS) || (v == SPK_NEG);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spike_lfsr16.sv
//------------------------------------------------------------------------------
// Module : spike_lfsr16
// Brief  : Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module spike_lfsr16 (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr_o
);

    localparam logic [15:0] C_SEED = 16'hACE1;

    logic [15:0] lfsr_q;
    logic        fb_d;

    assign fb_d = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= C_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], fb_d};
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/spike_broadcaster.sv
//------------------------------------------------------------------------------
// Module : spike_broadcaster
// Brief  : Captures all neuron spikes on start, picks one firing neuron
//          round-robin and broadcasts its {value,id} with a networkDone pulse.
//          Define SPIKE_BCAST_LFSR_EN to start each scan at a pseudo-random
//          neuron instead of the round-robin pointer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module spike_broadcaster #(
    parameter int TEN_DATA_WIDTH  = neurosa_pkg::TEN_DATA_WIDTH,
    parameter int NUM_NEURON      = neurosa_pkg::NUM_NEURON,
    parameter int NEURON_ID_WIDTH = neurosa_pkg::NEURON_ID_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [NUM_NEURON*TEN_DATA_WIDTH-1:0]   spike_vec,
    output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_in,
    output logic                                   networkDone,
    output logic                                   busy,
    output logic                                   winner_valid
);

    import neurosa_pkg::*;

    localparam int PTR_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(NUM_NEURON - 1);
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(NUM_NEURON - 1);

    bcast_state_t                             state_q;
    logic [NUM_NEURON*TEN_DATA_WIDTH-1:0]     cap_q;
    logic [PTR_W-1:0]                         ptr_q;
    logic [PTR_W-1:0]                         rr_ptr_q;
    logic [CNT_W-1:0]                         cnt_q;
    spike_pkt_t                               pkt_q;
    logic                                     done_q;
    logic                                     busy_q;
    logic                                     valid_q;

    logic [PTR_W-1:0]                         ptr_d;
    logic [PTR_W-1:0]                         start_ptr_d;
    logic [TEN_DATA_WIDTH-1:0]                cur_d;

    assign ptr_d = (ptr_q == C_LAST_PTR) ? '0 : ptr_q + 1'b1;
    assign cur_d = cap_q[ptr_q*TEN_DATA_WIDTH +: TEN_DATA_WIDTH];

`ifdef SPIKE_BCAST_LFSR_EN
    logic [15:0] lfsr_w;

    spike_lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (lfsr_w)
    );

    assign start_ptr_d = PTR_W'(lfsr_w % 16'(NUM_NEURON));
`else
    assign start_ptr_d = rr_ptr_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cap_q    <= '0;
            ptr_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            pkt_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        cap_q   <= spike_vec;
                        ptr_q   <= start_ptr_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (is_spike(cur_d)) begin
                        pkt_q.value <= cur_d;
                        pkt_q.id    <= NEURON_ID_WIDTH'(ptr_q);
                        valid_q     <= 1'b1;
                        rr_ptr_q    <= ptr_d;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else if (cnt_q == C_LAST_CNT) begin
                        // full sweep without a hit: broadcast an empty packet
                        pkt_q   <= '0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        ptr_q <= ptr_d;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign spike_in     = pkt_q;
    assign networkDone  = done_q;
    assign busy         = busy_q;
    assign winner_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_spike_broadcaster.sv
//------------------------------------------------------------------------------
// Module : tb_spike_broadcaster
// Brief  : Directed self-checking bench for spike_broadcaster.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spike_broadcaster;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] spike_vec;
    logic [11:0]  spike_in;
    logic         networkDone;
    logic         busy;
    logic         winner_valid;

    int n_vec;
    int n_err;

    spike_broadcaster u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .spike_vec    (spike_vec),
        .spike_in     (spike_in),
        .networkDone  (networkDone),
        .busy         (busy),
        .winner_valid (winner_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] vec1(input int n, input logic [1:0] v);
        logic [127:0] r;
        r = '0;
        r[n*2 +: 2] = v;
        return r;
    endfunction

    // One round; exp_edges = rising edges after the start edge until networkDone
    task automatic round(input string tag, input logic [127:0] vec, input int exp_edges,
                         input logic [11:0] exp_pkt, input logic exp_wv);
        int edges;
        edges = 0;
        spike_vec = vec;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        spike_vec = {64{2'b10}};  // must be ignored: captured on the start edge
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 200; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end else begin
                if (networkDone) begin
                    edges = 0;
                    break;
                end
                @(posedge clk);
                #1;
            end
            if (networkDone) begin
                edges = i;
                break;
            end
        end
        chk({tag, ".latency"}, 32'(edges), 32'(exp_edges));
        chk({tag, ".pkt"}, 32'(spike_in), 32'(exp_pkt));
        chk({tag, ".wv"}, 32'(winner_valid), 32'(exp_wv));
        @(posedge clk);
        #1;
        chk({tag, ".done_fall"}, {30'd0, networkDone, busy}, 32'd0);
        chk({tag, ".pkt_hold"}, 32'(spike_in), 32'(exp_pkt));
    endtask

    initial begin
        int pulses;
        int dn;
        logic busy_after;

        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        start     = 1'b0;
        spike_vec = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.pkt", 32'(spike_in), 32'd0);
        chk("rst.flags", {29'd0, networkDone, busy, winner_valid}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // single +1 spike, rr_ptr 0 -> 14
        round("single", vec1(13, 2'b10), 14, 12'h80D, 1'b1);
        // neurons 13 and 14 fire: scan starts at 14
        round("rr14", vec1(13, 2'b10) | vec1(14, 2'b10), 1, 12'h80E, 1'b1);

        // asynchronous reset in the middle of a scan
        spike_vec = '0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst.pkt", 32'(spike_in), 32'd0);
        chk("midrst.flags", {29'd0, networkDone, busy, winner_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (networkDone) pulses++;
        end
        chk("midrst.no_done", 32'(pulses), 32'd0);

        // round-robin after reset (rr_ptr back to 0)
        round("rr1", vec1(5, 2'b01) | vec1(40, 2'b10), 6, 12'h405, 1'b1);
        round("rr2", vec1(5, 2'b01) | vec1(40, 2'b10), 35, 12'h828, 1'b1);
        // from 41, hit 59 -> rr_ptr 60
        round("to60", vec1(59, 2'b10), 19, 12'h83B, 1'b1);
        // wrap: 60..63,0,1,2 -> offset 6, rr_ptr 3
        round("wrap", vec1(2, 2'b01), 7, 12'h402, 1'b1);
        round("rr3", vec1(2, 2'b01) | vec1(3, 2'b01), 1, 12'h403, 1'b1);
        // no spikes, one invalid code; rr_ptr stays 4
        round("none", vec1(7, 2'b11), 64, 12'h000, 1'b0);
        round("rr4", vec1(3, 2'b10) | vec1(4, 2'b10), 1, 12'h804, 1'b1);

        // start while busy is ignored; rr_ptr 5 so neuron 30 is offset 25
        spike_vec = vec1(30, 2'b10);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        pulses     = 0;
        dn         = 0;
        busy_after = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (networkDone) begin
                pulses++;
                if (dn == 0) dn = i;
            end
            if (dn != 0 && i == dn + 1) busy_after = busy;
            start = (i == 3);
        end
        chk("busy.pulses", 32'(pulses), 32'd1);
        chk("busy.latency", 32'(dn), 32'd26);
        chk("busy.fall", 32'(busy_after), 32'd0);
        chk("busy.pkt", 32'(spike_in), 32'h81E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
